aes_enc_round_seq: RTL

Iterative AES encryption sequencer that reuses one round datapath for every round of a block. It accepts a plaintext with a valid/ready handshake and fetches round keys from the external key store one index per cycle. It runs NR-1 full rounds and one final round, then holds the ciphertext until the consumer accepts it. It sits between the block-level I/O and the key-expansion store.

---
 rtl/aes_pkg.sv | 49 ++++
 rtl/aes_round_dp.sv | 71 +++++++
 rtl/aes_enc_round_seq.sv | 120 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and helpers: sequencer state encoding, block width,
// FIPS <-> row-major transpose and the forward S-box table.
package aes_pkg;

    localparam int AES_BLK_W = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Indexed as SBOX[high nibble][low nibble].
    localparam logic [0:15][0:15][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b[7:4]][b[3:0]];
    endfunction

    // FIPS byte 4c+r <-> row-major byte 4r+c; the mapping is its own inverse.
    function automatic logic [0:AES_BLK_W-1] transpose(input logic [0:AES_BLK_W-1] blk);
        logic [0:AES_BLK_W-1] t;
        t = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                t[8*(4*r+c) +: 8] = blk[8*(4*c+r) +: 8];
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/aes_round_dp.sv
// Combinational AES encryption round on a row-major state (byte 4r+c = row r, col c).
// Latency: none (pure logic). Backpressure: none, the caller owns all sequencing.
// final_rnd drops MixColumns and folds in the last round key.
module aes_round_dp
    import aes_pkg::*;
(
    input  logic [0:AES_BLK_W-1] state,
    input  logic [0:AES_BLK_W-1] round_key,
    input  logic                 final_rnd,
    input  logic [0:AES_BLK_W-1] last_key,
    output logic [0:AES_BLK_W-1] next_state
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [0:AES_BLK_W-1] add_round_key(input logic [0:AES_BLK_W-1] s,
                                                           input logic [0:AES_BLK_W-1] k);
        return s ^ k;
    endfunction

    function automatic logic [0:AES_BLK_W-1] sub_bytes(input logic [0:AES_BLK_W-1] s);
        logic [0:AES_BLK_W-1] t;
        t = '0;
        for (int i = 0; i < 16; i++) begin
            t[8*i +: 8] = sbox(s[8*i +: 8]);
        end
        return t;
    endfunction

    // Row r rotates left by r columns.
    function automatic logic [0:AES_BLK_W-1] shift_rows(input logic [0:AES_BLK_W-1] s);
        logic [0:AES_BLK_W-1] t;
        t = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                t[8*(4*r+c) +: 8] = s[8*(4*r+((c+r)%4)) +: 8];
            end
        end
        return t;
    endfunction

    function automatic logic [0:AES_BLK_W-1] mix_columns(input logic [0:AES_BLK_W-1] s);
        logic [0:AES_BLK_W-1] t;
        logic [7:0]           a [4];
        t = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a[r] = s[8*(4*r+c) +: 8];
            end
            for (int r = 0; r < 4; r++) begin
                t[8*(4*r+c) +: 8] = xtime(a[r]) ^ xtime(a[(r+1)%4]) ^ a[(r+1)%4]
                                  ^ a[(r+2)%4] ^ a[(r+3)%4];
            end
        end
        return t;
    endfunction

    logic [0:AES_BLK_W-1] ark;
    logic [0:AES_BLK_W-1] sb;
    logic [0:AES_BLK_W-1] sr;
    logic [0:AES_BLK_W-1] mc;

    assign ark        = add_round_key(state, round_key);
    assign sb         = sub_bytes(ark);
    assign sr         = shift_rows(sb);
    assign mc         = mix_columns(sr);
    assign next_state = final_rnd ? add_round_key(sr, last_key) : mc;

endmodule

// File: rtl/aes_enc_round_seq.sv
// Iterative AES encryptor reusing one round datapath; option macro AES_SEQ_BACK2BACK_EN.
// Latency: accept edge t -> out_valid after edge t+NR; ciphertext held until out_ready.
// Backpressure: in_ready low while a block is in flight or waiting; out_valid holds in DONE.
module aes_enc_round_seq
    import aes_pkg::*;
#(
    parameter int NR     = 10,
    parameter int KIDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [0:AES_BLK_W-1] plaintext,
    output logic [KIDX_W-1:0]    key_idx,
    input  logic [0:AES_BLK_W-1] key_data,
    input  logic [0:AES_BLK_W-1] key_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [0:AES_BLK_W-1] ciphertext,
    output logic                 busy
);

    if (NR >= 2**KIDX_W || NR < 2) begin : g_nr_check
        $error("aes_enc_round_seq: NR must be at least 2 and below 2**KIDX_W");
    end

    localparam logic [KIDX_W-1:0] NR_IDX   = KIDX_W'(NR);
    localparam logic [KIDX_W-1:0] LAST_IDX = KIDX_W'(NR - 1);
    localparam logic [KIDX_W-1:0] ONE_IDX  = KIDX_W'(1);

    state_t               state_q, state_d;
    logic [KIDX_W-1:0]    rnd_q, rnd_d;
    logic [0:AES_BLK_W-1] st_q, st_d;
    logic [0:AES_BLK_W-1] ct_q, ct_d;
    logic [0:AES_BLK_W-1] dp_out;
    logic                 final_rnd;

    assign final_rnd  = (state_q == ROUND) && (rnd_q == NR_IDX);
    assign out_valid  = (state_q == DONE);
    assign ciphertext = ct_q;

    aes_round_dp u_round_dp (
        .state      (st_q),
        .round_key  (key_data),
        .final_rnd  (final_rnd),
        .last_key   (key_last),
        .next_state (dp_out)
    );

    // Handshake/key-index outputs kept apart from next-state logic so the
    // external key read path does not form a loop through one process.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        key_idx  = '0;
        case (state_q)
            IDLE:  in_ready = 1'b1;
            ROUND: begin
                busy    = 1'b1;
                key_idx = rnd_q - ONE_IDX;
            end
            DONE: begin
                key_idx = LAST_IDX;
`ifdef AES_SEQ_BACK2BACK_EN
                in_ready = out_ready;
`else
                in_ready = 1'b0;
`endif
            end
            default: in_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        st_d    = st_q;
        ct_d    = ct_q;
        case (state_q)
            IDLE: state_d = IDLE;
            ROUND: begin
                if (final_rnd) begin
                    ct_d    = transpose(dp_out);
                    state_d = DONE;
                end else begin
                    st_d  = dp_out;
                    rnd_d = rnd_q + ONE_IDX;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A load in DONE (back-to-back build) overrides the return to IDLE.
        if (in_valid && in_ready) begin
            st_d    = transpose(plaintext);
            rnd_d   = ONE_IDX;
            state_d = ROUND;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            st_q    <= '0;
            ct_q    <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            st_q    <= st_d;
            ct_q    <= ct_d;
        end
    end

endmodule
